// File: rtl/uncache_access_unit.sv
// rtl/uncache_access_unit.sv - uncached load/store bridge onto the SRAM-like data bus
//
// Purpose: accepts uncached requests that already carry a physical address and
//    issues them as single-beat bus transactions. Stores are posted into an
//    in-order write buffer; a load is accepted only once the buffer has drained
//    and the bus is idle, so MMIO side effects stay in program order.
//
// Ports:
//    clk, rst          core clock, synchronous active-high reset
//    req_*             request from the MEM stage (valid/wr/size/paddr/wdata/wstrb)
//    req_ready         request accepted this cycle (combinational)
//    resp_valid/rdata  one-cycle load-data return
//    buf_empty         no buffered store and no write on the bus
//    bus_*             SRAM-like bus: req/wr/size/addr/wdata/wstrb out,
//                      addr_ok/data_ok/rdata in
module uncache_access_unit #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_paddr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        buf_empty,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_RADDR, S_RDATA} state_t;

   localparam logic [PTR_W:0] LP_FULL = (PTR_W + 1)'(DEPTH);

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_wb_addr  [DEPTH];
   logic [1:0]       r_wb_size  [DEPTH];
   logic [31:0]      r_wb_wdata [DEPTH];
   logic [3:0]       r_wb_wstrb [DEPTH];
   logic [PTR_W:0]   r_count, w_count_nxt;
   logic [PTR_W-1:0] r_head, r_tail;
   logic [31:0]      r_ld_addr;
   logic [1:0]       r_ld_size;
   logic             r_ld_pending;
   logic             r_resp_valid;
   logic [31:0]      r_resp_rdata;

   logic w_st_ok, w_ld_ok, w_enq, w_ld_acc, w_pop;

   // Any outstanding load blocks every new request until its response pulse,
   // which keeps a later store from overtaking it on the bus.
   assign w_st_ok   = !r_ld_pending && (r_count != LP_FULL);
   assign w_ld_ok   = !r_ld_pending && (r_count == '0) && (r_state == S_IDLE);
   assign req_ready = req_valid && (req_wr ? w_st_ok : w_ld_ok);
   assign w_enq     = req_ready && req_wr;
   assign w_ld_acc  = req_ready && !req_wr;
   assign w_pop     = (r_state == S_WDATA) && bus_data_ok;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_enq, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_head       <= '0;
         r_tail       <= '0;
         r_ld_pending <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_ld_addr    <= '0;
         r_ld_size    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_count      <= w_count_nxt;
         r_resp_valid <= (r_state == S_RDATA) && bus_data_ok;
         if ((r_state == S_RDATA) && bus_data_ok) begin
            r_resp_rdata <= bus_rdata;
         end
         if (w_enq) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         if (w_ld_acc) begin
            r_ld_pending <= 1'b1;
            r_ld_addr    <= req_paddr;
            r_ld_size    <= req_size;
         end else if (r_resp_valid) begin
            r_ld_pending <= 1'b0;
         end
      end
   end

   // Buffer payload needs no reset: only entries counted by r_count are read.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_wb_addr[r_tail]  <= req_paddr;
         r_wb_size[r_tail]  <= req_size;
         r_wb_wdata[r_tail] <= req_wdata;
         r_wb_wstrb[r_tail] <= req_wstrb;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         // A store enqueued this cycle starts its write next cycle.
         S_IDLE: begin
            if ((r_count != '0) || w_enq) begin
               w_state_nxt = S_WADDR;
            end else if (w_ld_acc) begin
               w_state_nxt = S_RADDR;
            end
         end
         S_WADDR: if (bus_addr_ok) w_state_nxt = S_WDATA;
         S_WDATA: if (bus_data_ok) w_state_nxt = (w_count_nxt != '0) ? S_WADDR : S_IDLE;
         // A data_ok coinciding with addr_ok is not taken as completion.
         S_RADDR: if (bus_addr_ok) w_state_nxt = S_RDATA;
         S_RDATA: if (bus_data_ok) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus_req   = 1'b0;
      bus_wr    = 1'b0;
      bus_size  = '0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_wstrb = '0;
      if (r_state == S_WADDR) begin
         bus_req   = 1'b1;
         bus_wr    = 1'b1;
         bus_size  = r_wb_size[r_head];
         bus_addr  = r_wb_addr[r_head];
         bus_wdata = r_wb_wdata[r_head];
         bus_wstrb = r_wb_wstrb[r_head];
      end else if (r_state == S_RADDR) begin
         bus_req   = 1'b1;
         bus_size  = r_ld_size;
         bus_addr  = r_ld_addr;
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign buf_empty  = (r_count == '0) && (r_state != S_WADDR) && (r_state != S_WDATA);

endmodule
